// File: rtl/alu_opb_stage.sv
// ALU operand-B select stage: immediate/forwarding select feeding a 2-entry skid buffer
// with valid/ready handshake, a sticky illegal-select flag and a saturating stall counter.
//
//  state    | meaning
//  ---------+---------------------------------------------------
//  ST_EMPTY | no operand held, accepting
//  ST_ONE   | operand in main register (opb), accepting
//  ST_TWO   | main and skid registers full, upstream stalled
module alu_opb_stage #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] rd2,
   input  logic [IMM_W-1:0]  imm,
   input  logic              alusrc,
   input  logic              imm_zext,
   input  logic [1:0]        fwd_sel,
   input  logic [DATA_W-1:0] fwd_exmem,
   input  logic [DATA_W-1:0] fwd_memwb,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] opb,
   output logic              sel_err,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_opb;
   logic [DATA_W-1:0] r_skid;
   logic              r_sel_err;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic [DATA_W-1:0] w_imm_ext;
   logic [DATA_W-1:0] w_sel;
   logic              w_accept;
   logic              w_illegal;

   always_comb begin
      if (imm_zext) w_imm_ext = DATA_W'(imm);
      else          w_imm_ext = DATA_W'($signed(imm));
   end

   // Illegal forward code falls back to the register-file value.
   always_comb begin
      w_sel = rd2;
      if (alusrc) begin
         w_sel = w_imm_ext;
      end else begin
         case (fwd_sel)
            2'b01:   w_sel = fwd_exmem;
            2'b10:   w_sel = fwd_memwb;
            default: w_sel = rd2;
         endcase
      end
   end

   assign in_ready  = (r_state != ST_TWO);
   assign out_valid = (r_state != ST_EMPTY);
   assign w_accept  = in_valid && in_ready;
   assign w_illegal = w_accept && !alusrc && (fwd_sel == 2'b11);

   assign opb       = r_opb;
   assign sel_err   = r_sel_err;
   assign stall_cnt = r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_opb   <= '0;
         r_skid  <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_opb   <= w_sel;
                  r_state <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && out_ready) begin
                  r_opb <= w_sel;
               end else if (w_accept) begin
                  r_skid  <= w_sel;
                  r_state <= ST_TWO;
               end else if (out_ready) begin
                  r_state <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_ready) begin
                  r_opb   <= r_skid;
                  r_state <= ST_ONE;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel_err   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         if (w_illegal)
            r_sel_err <= 1'b1;
         if (out_valid && !out_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_opb_stage.sv
// Self-checking bench for alu_opb_stage: scoreboard of selected operands plus
// per-scenario inline checks of handshake, flags and stall counting.
module tb_alu_opb_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] rd2 = '0;
   logic [15:0] imm = '0;
   logic        alusrc = 1'b0;
   logic        imm_zext = 1'b0;
   logic [1:0]  fwd_sel = 2'b00;
   logic [31:0] fwd_exmem = '0;
   logic [31:0] fwd_memwb = '0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, sel_err;
   logic [31:0] opb;
   logic [15:0] stall_cnt;

   logic        in_ready4, out_valid4, sel_err4;
   logic [31:0] opb4;
   logic [3:0]  stall_cnt4;

   int          checks = 0;
   int          errors = 0;
   int          n_pop = 0;
   int          exp_stall = 0;
   int          exp_stall4 = 0;
   logic [31:0] q[$];

   always #5 clk = ~clk;

   alu_opb_stage #(.DATA_W(32), .IMM_W(16), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .rd2(rd2), .imm(imm), .alusrc(alusrc), .imm_zext(imm_zext),
      .fwd_sel(fwd_sel), .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
      .out_valid(out_valid), .out_ready(out_ready), .opb(opb),
      .sel_err(sel_err), .stall_cnt(stall_cnt)
   );

   alu_opb_stage #(.DATA_W(32), .IMM_W(16), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .rd2(rd2), .imm(imm), .alusrc(alusrc), .imm_zext(imm_zext),
      .fwd_sel(fwd_sel), .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
      .out_valid(out_valid4), .out_ready(out_ready), .opb(opb4),
      .sel_err(sel_err4), .stall_cnt(stall_cnt4)
   );

   function automatic logic [31:0] model_sel(input logic as, input logic zx,
                                             input logic [15:0] im, input logic [1:0] fs,
                                             input logic [31:0] r2, input logic [31:0] ex,
                                             input logic [31:0] wb);
      if (as) return zx ? {16'h0000, im} : {{16{im[15]}}, im};
      case (fs)
         2'b01:   return ex;
         2'b10:   return wb;
         default: return r2;
      endcase
   endfunction

   // Handshakes are sampled mid-cycle; they take effect at the following rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            checks++;
            n_pop++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_unexpected opb=%h with nothing expected", opb);
            end else begin
               logic [31:0] e;
               e = q.pop_front();
               if (opb !== e) begin
                  errors++;
                  $display("FAIL scoreboard_opb got=%h exp=%h", opb, e);
               end
            end
         end
         if (in_valid && in_ready)
            q.push_back(model_sel(alusrc, imm_zext, imm, fwd_sel, rd2, fwd_exmem, fwd_memwb));
         if (out_valid && !out_ready) begin
            if (exp_stall < 65535) exp_stall++;
            if (exp_stall4 < 15) exp_stall4++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic as, input logic zx, input logic [15:0] im,
                       input logic [1:0] fs, input logic [31:0] r2,
                       input logic [31:0] ex, input logic [31:0] wb);
      bit done = 0;
      alusrc = as; imm_zext = zx; imm = im; fwd_sel = fs;
      rd2 = r2; fwd_exmem = ex; fwd_memwb = wb;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         if (in_ready) done = 1;
         step();
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL push_timeout in_ready=%b exp=1", in_ready);
      end
   endtask

   task automatic drain();
      bit done = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         if (!out_valid) done = 1;
         else step();
      end
      checks++;
      if (!done || q.size() != 0) begin
         errors++;
         $display("FAIL drain out_valid=%b pending=%0d exp 0/0", out_valid, q.size());
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      exp_stall = 0;
      exp_stall4 = 0;
      #3;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || opb !== 32'h0 ||
          sel_err !== 1'b0 || stall_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_state ov=%b ir=%b opb=%h se=%b sc=%h exp 0/1/0/0/0",
                  out_valid, in_ready, opb, sel_err, stall_cnt);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_select();
      out_ready = 1'b1;
      push(1'b1, 1'b0, 16'hFFF0, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0);
      checks++;
      if (out_valid !== 1'b1 || opb !== 32'hFFFF_FFF0) begin
         errors++;
         $display("FAIL sext_latency ov=%b opb=%h exp 1/fffffff0", out_valid, opb);
      end
      push(1'b1, 1'b1, 16'h8001, 2'b10, 32'h0, 32'h0, 32'h0);
      checks++;
      if (opb !== 32'h0000_8001) begin
         errors++;
         $display("FAIL zext opb=%h exp 00008001", opb);
      end
      push(1'b0, 1'b0, 16'h7777, 2'b01, 32'h1111_1111, 32'hA5A5_0001, 32'h5A5A_0002);
      push(1'b0, 1'b1, 16'h7777, 2'b10, 32'h1111_1111, 32'hA5A5_0001, 32'h5A5A_0002);
      push(1'b0, 1'b0, 16'h7777, 2'b00, 32'h1111_1111, 32'hA5A5_0001, 32'h5A5A_0002);
      push(1'b1, 1'b0, 16'h1234, 2'b01, 32'h1111_1111, 32'hA5A5_0001, 32'h5A5A_0002);
      drain();
      checks++;
      if (opb !== 32'h0000_1234) begin
         errors++;
         $display("FAIL hold_on_empty opb=%h exp 00001234", opb);
      end
   endtask

   task automatic test_skid();
      logic [15:0] sc0;
      int pop0;
      pop0 = n_pop;
      out_ready = 1'b0;
      push(1'b0, 1'b0, 16'h0, 2'b00, 32'd1, 32'h0, 32'h0);
      push(1'b0, 1'b0, 16'h0, 2'b00, 32'd2, 32'h0, 32'h0);
      rd2 = 32'd3; in_valid = 1'b1;
      sc0 = stall_cnt;
      step(); step(); step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || opb !== 32'd1) begin
         errors++;
         $display("FAIL skid_full ir=%b ov=%b opb=%h exp 0/1/00000001", in_ready, out_valid, opb);
      end
      checks++;
      if (stall_cnt !== 16'(exp_stall) || stall_cnt !== sc0 + 16'd3) begin
         errors++;
         $display("FAIL stall_count got=%0d exp=%0d", stall_cnt, exp_stall);
      end
      out_ready = 1'b1;
      push(1'b0, 1'b0, 16'h0, 2'b00, 32'd3, 32'h0, 32'h0);
      drain();
      checks++;
      if (n_pop - pop0 !== 3) begin
         errors++;
         $display("FAIL skid_count popped=%0d exp 3", n_pop - pop0);
      end
   endtask

   task automatic test_sel_err();
      out_ready = 1'b1;
      push(1'b1, 1'b0, 16'h0042, 2'b11, 32'h1234_5678, 32'h0, 32'h0);
      checks++;
      if (sel_err !== 1'b0) begin
         errors++;
         $display("FAIL sel_err_imm got=%b exp 0", sel_err);
      end
      push(1'b0, 1'b0, 16'h0042, 2'b11, 32'h1234_5678, 32'hFFFF_0000, 32'h0000_FFFF);
      checks++;
      if (sel_err !== 1'b1 || opb !== 32'h1234_5678) begin
         errors++;
         $display("FAIL sel_err_set se=%b opb=%h exp 1/12345678", sel_err, opb);
      end
      push(1'b0, 1'b0, 16'h0, 2'b01, 32'h0, 32'hCAFE_0001, 32'h0);
      drain();
      step(); step();
      checks++;
      if (sel_err !== 1'b1) begin
         errors++;
         $display("FAIL sel_err_sticky got=%b exp 1", sel_err);
      end
   endtask

   task automatic test_stall_sat();
      do_reset();
      checks++;
      if (sel_err !== 1'b0 || stall_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_clears se=%b sc=%h exp 0/0", sel_err, stall_cnt);
      end
      out_ready = 1'b0;
      push(1'b0, 1'b0, 16'h0, 2'b01, 32'h0, 32'h0BAD_F00D, 32'h0);
      repeat (20) step();
      checks++;
      if (stall_cnt4 !== 4'hF || stall_cnt4 !== 4'(exp_stall4)) begin
         errors++;
         $display("FAIL stall_saturate got=%h exp f", stall_cnt4);
      end
      checks++;
      if (stall_cnt !== 16'd20 || stall_cnt !== 16'(exp_stall)) begin
         errors++;
         $display("FAIL stall_wide got=%0d exp 20", stall_cnt);
      end
      checks++;
      if (opb !== 32'h0BAD_F00D) begin
         errors++;
         $display("FAIL stall_hold opb=%h exp 0badf00d", opb);
      end
      drain();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      push(1'b0, 1'b0, 16'h0, 2'b00, 32'h0000_00AA, 32'h0, 32'h0);
      push(1'b0, 1'b0, 16'h0, 2'b00, 32'h0000_00BB, 32'h0, 32'h0);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL two_state ir=%b ov=%b exp 0/1", in_ready, out_valid);
      end
      #2;
      rst_n = 1'b0;
      q.delete();
      exp_stall = 0;
      exp_stall4 = 0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || opb !== 32'h0 || in_ready !== 1'b1 || stall_cnt !== 16'h0) begin
         errors++;
         $display("FAIL async_reset ov=%b opb=%h ir=%b sc=%h exp 0/0/1/0",
                  out_valid, opb, in_ready, stall_cnt);
      end
      step();
      rst_n = 1'b1;
      step();
      out_ready = 1'b1;
      push(1'b1, 1'b0, 16'h8000, 2'b00, 32'h0, 32'h0, 32'h0);
      checks++;
      if (opb !== 32'hFFFF_8000) begin
         errors++;
         $display("FAIL post_reset opb=%h exp ffff8000", opb);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_select();
      test_skid();
      test_sel_err();
      test_stall_sat();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
